// File: rtl/pipe_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_ctrl -- pipeline hazard / stall / flush controller
//
// Purpose:
//   Produces the per-stage hold vector for a classic 6-stage pipe
//   (PC, IF, ID, EX, MEM, WB). It handles three situations:
//     * load-use hazards (a one-cycle bubble behind a load),
//     * multi-cycle EX operations such as divide, with a watchdog timeout,
//     * exception/redirect flushes, which carry a new PC.
//   Priority within any cycle: flush request > multi-cycle handling > load-use.
//
// Parameters:
//   MC_TIMEOUT   maximum MC_WAIT cycles before the multi-cycle op is aborted
//                (legal range 2..255; the wait counter is 8 bits wide)
//
// Ports:
//   clk            in   1   rising-edge clock
//   rst            in   1   synchronous active-high reset
//   id_reg1_read   in   1   ID reads its rs operand
//   id_reg1_addr   in   5   ID rs address
//   id_reg2_read   in   1   ID reads its rt operand
//   id_reg2_addr   in   5   ID rt address
//   ex_is_load     in   1   EX instruction is a load
//   ex_wreg        in   1   EX instruction writes a register
//   ex_wd          in   5   EX destination register
//   ex_mc_start    in   1   EX starts a multi-cycle op this cycle
//   ex_mc_done     in   1   multi-cycle result valid this cycle
//   flush_req      in   1   redirect request (single-cycle pulse)
//   flush_pc       in   32  redirect target, valid with flush_req
//   stall          out  6   combinational hold vector {WB,MEM,EX,ID,IF,PC}
//   flush          out  1   registered one-cycle flush pulse
//   new_pc         out  32  registered redirect target (holds last value)
//   mc_abort       out  1   registered one-cycle multi-cycle cancel pulse
//   stall_cycles   out  32  saturating count of cycles with stall != 0
// ---------------------------------------------------------------------------
module pipe_ctrl #(
  parameter int MC_TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_reg1_read,
  input  logic [4:0]  id_reg1_addr,
  input  logic        id_reg2_read,
  input  logic [4:0]  id_reg2_addr,
  input  logic        ex_is_load,
  input  logic        ex_wreg,
  input  logic [4:0]  ex_wd,
  input  logic        ex_mc_start,
  input  logic        ex_mc_done,
  input  logic        flush_req,
  input  logic [31:0] flush_pc,
  output logic [5:0]  stall,
  output logic        flush,
  output logic [31:0] new_pc,
  output logic        mc_abort,
  output logic [31:0] stall_cycles
);

  // Hold patterns. A multi-cycle op freezes everything up to and including
  // EX; a load-use bubble freezes only the front end (PC, IF, ID) so the
  // load itself keeps moving into MEM.
  localparam logic [5:0] STALL_NONE = 6'b000000;
  localparam logic [5:0] STALL_LU   = 6'b000111;
  localparam logic [5:0] STALL_MC   = 6'b001111;

  localparam logic [7:0] MC_LIMIT = 8'(MC_TIMEOUT);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    MC_WAIT = 2'd1,
    FLUSH   = 2'd2
  } state_t;

  state_t      state_reg;
  state_t      state_next;
  logic [7:0]  mc_cnt_reg;
  logic [7:0]  mc_cnt_next;

  logic        flush_next;
  logic [31:0] new_pc_next;
  logic        mc_abort_next;
  logic [31:0] stall_cycles_next;

  logic        lu;
  logic        rs_hit;
  logic        rt_hit;
  logic        mc_timeout_hit;

  // -------------------------------------------------------------------------
  // Hazard detection. Register 0 is hard-wired zero, so a load targeting it
  // can never produce a dependency.
  // -------------------------------------------------------------------------
  assign rs_hit = id_reg1_read && (id_reg1_addr == ex_wd);
  assign rt_hit = id_reg2_read && (id_reg2_addr == ex_wd);
  assign lu     = ex_is_load && ex_wreg && (ex_wd != 5'd0) && (rs_hit || rt_hit);

  assign mc_timeout_hit = (mc_cnt_reg == MC_LIMIT);

  // -------------------------------------------------------------------------
  // State register (also carries the wait counter and registered outputs).
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= RUN;
      mc_cnt_reg   <= 8'd0;
      flush        <= 1'b0;
      new_pc       <= 32'd0;
      mc_abort     <= 1'b0;
      stall_cycles <= 32'd0;
    end else begin
      state_reg    <= state_next;
      mc_cnt_reg   <= mc_cnt_next;
      flush        <= flush_next;
      new_pc       <= new_pc_next;
      mc_abort     <= mc_abort_next;
      stall_cycles <= stall_cycles_next;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic.
  // -------------------------------------------------------------------------
  always_comb begin
    state_next  = state_reg;
    mc_cnt_next = mc_cnt_reg;

    case (state_reg)
      RUN: begin
        if (flush_req) begin
          state_next  = FLUSH;
          mc_cnt_next = 8'd0;
        end else if (ex_mc_start && !ex_mc_done) begin
          // The start cycle itself is the first stalled cycle, so the
          // counter enters MC_WAIT already at 1.
          state_next  = MC_WAIT;
          mc_cnt_next = 8'd1;
        end
      end

      MC_WAIT: begin
        if (flush_req) begin
          state_next  = FLUSH;
          mc_cnt_next = 8'd0;
        end else if (ex_mc_done) begin
          state_next  = RUN;
          mc_cnt_next = 8'd0;
        end else if (mc_timeout_hit) begin
          state_next  = RUN;
          mc_cnt_next = 8'd0;
        end else begin
          mc_cnt_next = mc_cnt_reg + 8'd1;
        end
      end

      FLUSH: begin
        // A fresh redirect arriving during the flush cycle simply extends
        // the flush with the newer target.
        if (flush_req) begin
          state_next = FLUSH;
        end else begin
          state_next = RUN;
        end
        mc_cnt_next = 8'd0;
      end

      default: begin
        state_next  = RUN;
        mc_cnt_next = 8'd0;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Output logic: the combinational hold vector plus the next values of the
  // registered pulse/PC/counter outputs.
  // -------------------------------------------------------------------------
  always_comb begin
    stall             = STALL_NONE;
    flush_next        = 1'b0;
    mc_abort_next     = 1'b0;
    new_pc_next       = new_pc;
    stall_cycles_next = stall_cycles;

    case (state_reg)
      RUN: begin
        if (flush_req) begin
          flush_next  = 1'b1;
          new_pc_next = flush_pc;
        end else if (ex_mc_start) begin
          // A start that completes in the same cycle needs no hold, and it
          // still outranks any load-use hazard seen in that cycle.
          if (!ex_mc_done) begin
            stall = STALL_MC;
          end
        end else if (lu) begin
          stall = STALL_LU;
        end
      end

      MC_WAIT: begin
        if (flush_req) begin
          flush_next    = 1'b1;
          mc_abort_next = 1'b1;
          new_pc_next   = flush_pc;
        end else if (ex_mc_done) begin
          stall = STALL_NONE;
        end else if (mc_timeout_hit) begin
          // Release the pipe on the timeout cycle; the abort pulse tells EX
          // to discard the unfinished operation.
          mc_abort_next = 1'b1;
        end else begin
          stall = STALL_MC;
        end
      end

      FLUSH: begin
        if (flush_req) begin
          flush_next  = 1'b1;
          new_pc_next = flush_pc;
        end
      end

      default: begin
        stall = STALL_NONE;
      end
    endcase

    // Reset wins over everything for the hold vector as well.
    if (rst) begin
      stall = STALL_NONE;
    end

    if ((stall != STALL_NONE) && (stall_cycles != 32'hFFFF_FFFF)) begin
      stall_cycles_next = stall_cycles + 32'd1;
    end
  end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 Parameter MC_TIMEOUT, default 64, maximum MC_WAIT cycles before forced abort (range 2..255).
REQ-002 clk  input  1  rising-edge clock.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 id_reg1_read  input  1  ID stage reads rs operand.
REQ-005 id_reg1_addr  input  5  ID rs address.
REQ-006 id_reg2_read  input  1  ID stage reads rt operand.
REQ-007 id_reg2_addr  input  5  ID rt address.
REQ-008 ex_is_load  input  1  instruction in EX is a load.
REQ-009 ex_wreg  input  1  EX instruction writes a register.
REQ-010 ex_wd  input  5  EX destination register address.
REQ-011 ex_mc_start  input  1  EX begins a multi-cycle operation (e.g. divide) this cycle.
REQ-012 ex_mc_done  input  1  multi-cycle result valid this cycle.
REQ-013 flush_req  input  1  exception/redirect request, single-cycle pulse.
REQ-014 flush_pc  input  32  redirect target, valid with flush_req.
REQ-015 stall  output  6  hold vector: bit0 PC, bit1 IF, bit2 ID, bit3 EX, bit4 MEM, bit5 WB.
REQ-016 flush  output  1  registered one-cycle pipeline flush pulse.
REQ-017 new_pc  output  32  registered redirect target, meaningful while flush=1.
REQ-018 mc_abort  output  1  registered one-cycle pulse; multi-cycle op cancelled.
REQ-019 stall_cycles  output  32  saturating count of cycles with stall!=0.

Function
REQ-020 States: RUN, MC_WAIT, FLUSH; 8-bit wait counter mc_cnt.
REQ-021 Load-use hazard lu = ex_is_load & ex_wreg & ex_wd!=0 & ((id_reg1_read & id_reg1_addr==ex_wd) | (id_reg2_read & id_reg2_addr==ex_wd)).
REQ-022 stall is combinational from state and inputs; flush, new_pc, mc_abort, stall_cycles are registered.
REQ-023 Priority per cycle: flush_req > multi-cycle handling > load-use.
REQ-024 RUN, flush_req=1: stall=0; next state FLUSH; new_pc<=flush_pc; flush<=1.
REQ-025 RUN, ex_mc_start=1 and ex_mc_done=0: stall=6'b001111; next MC_WAIT; mc_cnt<=1.
REQ-026 RUN, ex_mc_start=1 and ex_mc_done=1: stall=0; stay RUN (single-cycle completion).
REQ-027 RUN, lu=1 (no higher priority event): stall=6'b000111 for that cycle only; stay RUN.
REQ-028 RUN, none of the above: stall=0.
REQ-029 MC_WAIT, flush_req=1: stall=0; next FLUSH; mc_abort<=1; flush<=1; new_pc<=flush_pc.
REQ-030 MC_WAIT, ex_mc_done=1: stall=0; next RUN; mc_cnt<=0.
REQ-031 MC_WAIT, otherwise: stall=6'b001111; mc_cnt increments; when mc_cnt==MC_TIMEOUT, next RUN, mc_abort<=1, stall=0 that cycle.
REQ-032 MC_WAIT ignores lu and ex_mc_start.
REQ-033 FLUSH lasts one cycle: stall=0; flush_req=1 here re-enters FLUSH with the new flush_pc (flush stays 1); else next RUN, flush<=0.
REQ-034 FLUSH ignores ex_mc_start and lu.
REQ-035 flush and mc_abort are 0 in every cycle not explicitly setting them; new_pc holds last value.
REQ-036 stall_cycles increments by 1 each cycle stall!=0, saturates at 32'hFFFFFFFF, never wraps.
REQ-037 ex_wd==0 never raises lu.

Reset
REQ-038 rst=1 at a clock edge: state<=RUN, mc_cnt<=0, flush<=0, new_pc<=0, mc_abort<=0, stall_cycles<=0.
REQ-039 While rst=1: stall=0 regardless of inputs; reset mid-MC_WAIT or mid-FLUSH discards state with no abort pulse.

Verification
REQ-040 Load-use: ex_is_load=1, ex_wreg=1, ex_wd=5, id_reg2_read=1, id_reg2_addr=5 for one cycle -> stall=6'b000111 that cycle only, stall_cycles=1.
REQ-041 Divide: ex_mc_start pulse, ex_mc_done after 10 cycles -> stall=6'b001111 for 10 cycles, 0 on done cycle, no mc_abort.
REQ-042 Timeout: MC_TIMEOUT=4, ex_mc_start, no done -> stall held 4 cycles, then mc_abort=1 one cycle, state RUN.
REQ-043 Flush during MC_WAIT: flush_req with flush_pc=32'h00000180 -> next cycle flush=1, mc_abort=1, new_pc=32'h00000180; following cycle flush=0.
REQ-044 Back-to-back flush: flush_req in RUN (pc A) and FLUSH (pc B) -> flush=1 two cycles, new_pc A then B.
REQ-045 Priority/reset: flush_req, ex_mc_start and lu together -> stall=0, FLUSH entered; rst asserted in MC_WAIT -> next cycle RUN, all outputs zero.
